// File: rtl/cfg_loader_if.sv
// Host-to-loader configuration word stream (valid/ready).
// Ports: s_valid/s_data driven by the host (master); s_ready driven by the loader (slave).
// s_data[HALF_W-1:0] carries bank A bits, s_data[2*HALF_W-1:HALF_W] carries bank B bits.
interface cfg_loader_if #(
  parameter int HALF_W = 8
) ();
  logic                  s_valid;
  logic                  s_ready;
  logic [2*HALF_W-1:0]   s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/cfg_loader.sv
// Bitstream loader: serializes host words MSB-first onto the two CRAM config chains
// (bank A, bank B), counting exactly CHAIN_LEN bits per bank before releasing the fabric.
// Ports: clk, rst (async, active-high), start, abort, s (word stream, slave side),
// config_en, shift_en, config_data_A/B (chain drive), busy, done, bits_shifted (status).
module cfg_loader #(
  parameter int HALF_W    = 8,
  parameter int CHAIN_LEN = 240,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  cfg_loader_if.slave      s,
  output logic             config_en,
  output logic             shift_en,
  output logic             config_data_A,
  output logic             config_data_B,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bits_shifted
);

  localparam int WB_W = $clog2(HALF_W + 1);
  localparam logic [CNT_W-1:0] LP_LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  LP_LAST_WB  = WB_W'(HALF_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [HALF_W-1:0] r_sh_a;
  logic [HALF_W-1:0] r_sh_b;
  logic [WB_W-1:0]   r_wcnt;
  logic [CNT_W-1:0]  r_bits;
  logic              w_last_bit;
  logic              w_word_end;

  // Both tests look at the counters before this edge's increment, i.e. they ask
  // "is the bit being presented right now the last one (of the chain / of the word)".
  assign w_last_bit = (r_bits == LP_LAST_BIT);
  assign w_word_end = (r_wcnt == LP_LAST_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_WAIT;
      ST_WAIT:  if (s.s_valid) w_state_nxt = ST_SHIFT;
      // Chain-length check comes first so a partial final word is cut short.
      ST_SHIFT: begin
        if (w_last_bit)      w_state_nxt = ST_DONE;
        else if (w_word_end) w_state_nxt = ST_WAIT;
      end
      ST_DONE:  if (start) w_state_nxt = ST_WAIT;
      default:  w_state_nxt = ST_IDLE;
    endcase
    // Abort overrides start and any handshake in the same cycle.
    if (abort) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_a <= '0;
      r_sh_b <= '0;
      r_wcnt <= '0;
      r_bits <= '0;
    end else if (abort) begin
      // Shift registers are left alone; the chains keep whatever was shifted.
      r_wcnt <= '0;
      r_bits <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_wcnt <= '0;
            r_bits <= '0;
          end
        end
        ST_WAIT: begin
          if (s.s_valid) begin
            r_sh_a <= s.s_data[HALF_W-1:0];
            r_sh_b <= s.s_data[2*HALF_W-1:HALF_W];
            r_wcnt <= '0;
          end
        end
        ST_SHIFT: begin
          r_sh_a <= r_sh_a << 1;
          r_sh_b <= r_sh_b << 1;
          r_wcnt <= r_wcnt + WB_W'(1);
          r_bits <= r_bits + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are a pure decode of registered state.
  always_comb begin
    config_en     = (r_state == ST_WAIT) || (r_state == ST_SHIFT);
    busy          = config_en;
    s.s_ready     = (r_state == ST_WAIT);
    shift_en      = (r_state == ST_SHIFT);
    config_data_A = (r_state == ST_SHIFT) && r_sh_a[HALF_W-1];
    config_data_B = (r_state == ST_SHIFT) && r_sh_b[HALF_W-1];
    done          = (r_state == ST_DONE);
    bits_shifted  = r_bits;
  end

endmodule

// File: tb/tb_cfg_loader.sv
module tb_cfg_loader;
  localparam int HALF_W    = 8;
  localparam int CHAIN_LEN = 12;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic config_en, shift_en, config_data_A, config_data_B, busy, done;
  logic [CNT_W-1:0] bits_shifted;

  cfg_loader_if #(.HALF_W(HALF_W)) u_if ();

  cfg_loader #(.HALF_W(HALF_W), .CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .s(u_if),
    .config_en(config_en), .shift_en(shift_en),
    .config_data_A(config_data_A), .config_data_B(config_data_B),
    .busy(busy), .done(done), .bits_shifted(bits_shifted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Tile-side view of the chains: capture each presented bit on a shift strobe.
  logic [CHAIN_LEN-1:0] chain_a = '0;
  logic [CHAIN_LEN-1:0] chain_b = '0;
  int shift_total = 0;
  always @(posedge clk) begin
    if (!rst && shift_en) begin
      chain_a     <= {chain_a[CHAIN_LEN-2:0], config_data_A};
      chain_b     <= {chain_b[CHAIN_LEN-2:0], config_data_B};
      shift_total <= shift_total + 1;
    end
  end

  // Behavioural model: mode 0 idle, 1 loading, 2 done; m_left = bits of the
  // current word still to go (0 while waiting for a word); queues hold them.
  int m_mode = 0;
  int m_cnt  = 0;
  int m_left = 0;
  bit qa[$];
  bit qb[$];

  always @(negedge clk) begin
    bit e_cfg, e_sh, e_rdy, e_done, e_a, e_b;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_left = 0;
      qa.delete(); qb.delete();
    end else begin
      e_cfg  = (m_mode == 1);
      e_sh   = e_cfg && (m_left > 0);
      e_rdy  = e_cfg && (m_left == 0);
      e_done = (m_mode == 2);
      e_a    = e_sh ? qa[0] : 1'b0;
      e_b    = e_sh ? qb[0] : 1'b0;
      check("config_en", config_en, e_cfg);
      check("busy", busy, e_cfg);
      check("shift_en", shift_en, e_sh);
      check("s_ready", u_if.s_ready, e_rdy);
      check("done", done, e_done);
      check("bits_shifted", bits_shifted, m_cnt);
      check("data_A", config_data_A, e_a);
      check("data_B", config_data_B, e_b);
      // advance using the inputs the next rising edge will see
      if (abort) begin
        m_mode = 0; m_cnt = 0; m_left = 0;
        qa.delete(); qb.delete();
      end else if (m_mode == 1 && m_left > 0) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
        m_cnt++;
        m_left--;
        if (m_cnt == CHAIN_LEN) begin
          m_mode = 2; m_left = 0;
          qa.delete(); qb.delete();
        end
      end else if (m_mode == 1 && u_if.s_valid) begin
        for (int i = HALF_W - 1; i >= 0; i--) begin
          qa.push_back(u_if.s_data[i]);
          qb.push_back(u_if.s_data[HALF_W + i]);
        end
        m_left = (CHAIN_LEN - m_cnt < HALF_W) ? CHAIN_LEN - m_cnt : HALF_W;
      end else if (m_mode != 1 && start) begin
        m_mode = 1; m_cnt = 0; m_left = 0;
      end
    end
  end

  // Chain image after a full load: halves concatenated MSB-first, cut at CHAIN_LEN.
  function automatic logic [CHAIN_LEN-1:0] exp_chain(input logic [HALF_W-1:0] h0,
                                                    input logic [HALF_W-1:0] h1);
    logic [2*HALF_W-1:0] cat;
    cat = {h0, h1};
    return cat[2*HALF_W-1 -: CHAIN_LEN];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [2*HALF_W-1:0] w, input int stall, input bit rand_start);
    bit got, rdy;
    got = 1'b0;
    u_if.s_valid = 1'b0;
    repeat (stall) tick();
    u_if.s_valid = 1'b1;
    u_if.s_data  = w;
    for (int i = 0; i < 100 && !got; i++) begin
      if (rand_start) start = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      rdy = u_if.s_ready;
      tick();
      start = 1'b0;
      if (rdy) got = 1'b1;
    end
    u_if.s_valid = 1'b0;
    u_if.s_data  = 16'($urandom);
    if (!got) check("handshake_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    if (!ok) check("done_timeout", 32'(ok), 32'd1);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [2*HALF_W-1:0] w0, w1;
    u_if.s_valid = 1'b0;
    u_if.s_data  = '0;

    // reset state
    repeat (2) tick();
    check("rst_config_en", config_en, 0);
    check("rst_s_ready", u_if.s_ready, 0);
    check("rst_bits", bits_shifted, 0);
    rst = 1'b0;
    repeat (2) tick();

    // two words, 12-bit chain: A = 0xA5 then 1111, B = 0x3C then 0000
    s0 = shift_total;
    pulse_start();
    send_word(16'h3CA5, 0, 0);
    send_word(16'h0FF0, 0, 0);
    wait_done();
    check("lit_chain_a", chain_a, 12'hA5F);
    check("lit_chain_b", chain_b, 12'h3C0);
    check("lit_shift_cnt", shift_total - s0, 12);
    check("lit_done", done, 1);
    check("lit_bits", bits_shifted, 12);
    check("lit_cfg_en_off", config_en, 0);

    // a third word is never accepted
    u_if.s_valid = 1'b1;
    u_if.s_data  = 16'h1234;
    repeat (10) tick();
    u_if.s_valid = 1'b0;
    check("lit_no_third_bits", bits_shifted, 12);
    check("lit_no_third_chain", chain_a, 12'hA5F);

    // start in DONE, then a stalled load of the same data
    pulse_start();
    check("lit_restart_done", done, 0);
    check("lit_restart_bits", bits_shifted, 0);
    check("lit_restart_rdy", u_if.s_ready, 1);
    chain_a = '0;
    chain_b = '0;
    send_word(16'h3CA5, 5, 0);
    repeat (10) tick();
    check("lit_stall_cfg", config_en, 1);
    check("lit_stall_shift", shift_en, 0);
    check("lit_stall_bits", bits_shifted, 8);
    send_word(16'h0FF0, 5, 0);
    wait_done();
    check("lit_stall_chain_a", chain_a, 12'hA5F);
    check("lit_stall_chain_b", chain_b, 12'h3C0);

    // abort together with start on the 3rd SHIFT cycle
    pulse_start();
    send_word(16'hA55A, 0, 0);
    tick();
    tick();
    check("lit_pre_abort_bits", bits_shifted, 2);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("lit_abort_cfg", config_en, 0);
    check("lit_abort_busy", busy, 0);
    check("lit_abort_bits", bits_shifted, 0);
    check("lit_abort_done", done, 0);
    w0 = 16'($urandom);
    w1 = 16'($urandom);
    pulse_start();
    send_word(w0, 0, 0);
    // start during SHIFT changes nothing
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lit_start_in_shift", bits_shifted, 2);
    send_word(w1, 1, 0);
    wait_done();
    check("post_abort_chain_a", chain_a, exp_chain(w0[7:0], w1[7:0]));
    check("post_abort_chain_b", chain_b, exp_chain(w0[15:8], w1[15:8]));

    // randomized loads, stalls, stray starts and aborts
    for (int it = 0; it < 40; it++) begin
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      pulse_start();
      send_word(w0, $urandom_range(0, 3), 1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 9)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
      end else begin
        send_word(w1, $urandom_range(0, 3), 1);
        wait_done();
        check("rand_chain_a", chain_a, exp_chain(w0[7:0], w1[7:0]));
        check("rand_chain_b", chain_b, exp_chain(w0[15:8], w1[15:8]));
      end
    end

    // asynchronous reset mid-word
    pulse_start();
    send_word(16'hF0F0, 0, 0);
    tick();
    tick();
    #1;
    rst = 1'b1;
    #1;
    check("arst_config_en", config_en, 0);
    check("arst_shift_en", shift_en, 0);
    check("arst_busy", busy, 0);
    check("arst_data_A", config_data_A, 0);
    check("arst_bits", bits_shifted, 0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_idle_busy", busy, 0);
    check("arst_idle_done", done, 0);
    w0 = 16'($urandom);
    w1 = 16'($urandom);
    pulse_start();
    send_word(w0, 0, 0);
    send_word(w1, 2, 0);
    wait_done();
    check("post_rst_chain_a", chain_a, exp_chain(w0[7:0], w1[7:0]));
    check("post_rst_chain_b", chain_b, exp_chain(w0[15:8], w1[15:8]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
